// File: rtl/add_seq_pkg.sv
// ============================================================================
// Module : add_seq_pkg
// Brief  : Shared widths, FSM state encoding and overflow helper for add_seq_32
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package add_seq_pkg;

  localparam int unsigned c_DATA_W = 32;
  localparam int unsigned c_HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_16.sv
// ============================================================================
// Module : cla_16
// Brief  : 16-bit carry-look-ahead adder, four 4-bit groups with group lookahead
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_grp
      logic [3:0] w_gi;
      logic [3:0] w_pi;
      logic [3:0] w_ci;

      assign w_gi = w_g[4*k +: 4];
      assign w_pi = w_p[4*k +: 4];

      assign w_gg[k] = w_gi[3]
                     | (w_pi[3] & w_gi[2])
                     | (w_pi[3] & w_pi[2] & w_gi[1])
                     | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
      assign w_gp[k] = &w_pi;

      assign w_ci[0] = w_gc[k];
      assign w_ci[1] = w_gi[0] | (w_pi[0] & w_gc[k]);
      assign w_ci[2] = w_gi[1] | (w_pi[1] & w_gi[0])
                     | (w_pi[1] & w_pi[0] & w_gc[k]);
      assign w_ci[3] = w_gi[2] | (w_pi[2] & w_gi[1])
                     | (w_pi[2] & w_pi[1] & w_gi[0])
                     | (w_pi[2] & w_pi[1] & w_pi[0] & w_gc[k]);

      assign sum[4*k +: 4] = w_pi ^ w_ci;
    end
  endgenerate

  // Second-level lookahead across the four groups.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | ((&w_gp) & cin);

  assign cout = w_gc[4];

endmodule

`default_nettype wire

// File: rtl/add_seq_32.sv
// ============================================================================
// Module : add_seq_32
// Brief  : 32-bit adder over two cycles, one shared 16-bit CLA, valid/ready I/O
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_seq_32
  import add_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [c_DATA_W-1:0] a,
  input  logic [c_DATA_W-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [c_DATA_W-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  state_t              r_state;
  logic [c_DATA_W-1:0] r_a;
  logic [c_DATA_W-1:0] r_b;
  logic                r_cin;
  logic                r_carry;
  logic [c_DATA_W-1:0] r_sum;
  logic                r_cout;
  logic                r_ovf;

  logic [c_HALF_W-1:0] w_add_a;
  logic [c_HALF_W-1:0] w_add_b;
  logic                w_add_cin;
  logic [c_HALF_W-1:0] w_add_sum;
  logic                w_add_cout;

  // Adder operands follow the state: upper halves in HI, lower halves otherwise.
  assign w_add_a   = (r_state == HI) ? r_a[c_DATA_W-1:c_HALF_W] : r_a[c_HALF_W-1:0];
  assign w_add_b   = (r_state == HI) ? r_b[c_DATA_W-1:c_HALF_W] : r_b[c_HALF_W-1:0];
  assign w_add_cin = (r_state == HI) ? r_carry : r_cin;

  cla_16 u_cla (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (w_add_cin),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_cin   <= cin;
            r_state <= LO;
          end
        end
        LO: begin
          r_sum[c_HALF_W-1:0] <= w_add_sum;
          r_carry             <= w_add_cout;
          r_state             <= HI;
        end
        HI: begin
          r_sum[c_DATA_W-1:c_HALF_W] <= w_add_sum;
          r_cout                     <= w_add_cout;
          r_ovf   <= add_ovf(r_a[c_DATA_W-1], r_b[c_DATA_W-1], w_add_sum[c_HALF_W-1]);
          r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake flags depend only on state; in_ready is also held low during reset.
  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: doc/add_seq_32.md
ADD_SEQ_32 -- requirements
Module: add_seq_32

Interface
REQ-001 Parameters: none; all widths fixed (32-bit operands, 16-bit half-word).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers operands a, b, cin.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  operand A.
REQ-007 b  input  32  operand B.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 sum  output  32  registered result, (a + b + cin) mod 2^32.
REQ-012 cout  output  1  registered carry out of bit 31.
REQ-013 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-014 The block SHALL compute the 32-bit add over two cycles by time-sharing one 16-bit carry-look-ahead adder: low half first, then high half.
REQ-015 FSM states SHALL be IDLE, LO, HI and DONE.
REQ-016 IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and cin into operand registers, then go to LO. Otherwise stay in IDLE.
REQ-017 LO: adder inputs are a_r[15:0], b_r[15:0] and cin_r. Register the adder sum into sum[15:0] and its carry into carry_r, then go to HI.
REQ-018 HI: adder inputs are a_r[31:16], b_r[31:16] and carry_r. Register the adder sum into sum[31:16] and its carry into cout. Register ovf = (a_r[31]==b_r[31]) && (new sum[31]!=a_r[31]). Then go to DONE.
REQ-019 DONE: out_valid=1. sum, cout and ovf SHALL hold stable until out_valid&&out_ready. On that handshake, go to IDLE.
REQ-020 Latency: if operands are accepted at edge E0, out_valid SHALL be high from edge E0+2.
REQ-021 Throughput: at most one transaction per 4 cycles when out_ready and in_valid are held high; in_ready=0 in LO, HI and DONE.
REQ-022 in_valid SHALL be ignored in LO, HI and DONE. Upstream changes to a, b and cin after acceptance SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 in_ready and out_valid SHALL be decoded from state only, with no combinational path from in_valid or out_ready.
REQ-025 sum[15:0] is written in LO, so partial results SHALL be visible on sum in HI. Consumers SHALL qualify sum with out_valid.

Reset
REQ-026 While rst=1: state=IDLE, out_valid=0, in_ready=0, sum=0, cout=0, ovf=0, carry_r=0, and operand registers=0.
REQ-027 Reset asserted in LO, HI or DONE SHALL abort the transaction with no result delivered.
REQ-028 The first cycle after rst deasserts, in_ready=1.

Structure
REQ-029 A shared package add_seq_pkg SHALL hold the state enumeration (IDLE, LO, HI, DONE) and the width constants (32 and 16).
REQ-030 Exactly one sub-module instance SHALL be used: the existing cla_16 (a, b, cin, sum, cout), with its inputs muxed by state. No second adder SHALL be used.
REQ-031 All outputs except in_ready and out_valid SHALL come directly from flops.

Verification
REQ-032 Carry across halves: a=0x0000FFFF, b=0x00000001, cin=0 -> sum=0x00010000, cout=0, ovf=0, out_valid exactly 2 edges after accept.
REQ-033 Full wrap: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
REQ-034 Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
REQ-035 Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> sum, cout and ovf stable, in_ready=0, new operands not captured. Release out_ready -> IDLE, then accept.
REQ-036 Reset mid-operation: assert rst during HI -> all outputs 0 immediately, out_valid never rises. After release, a=0x12345678, b=0x11111111 -> sum=0x23456789.
REQ-037 Streaming: in_valid=1 and out_ready=1 continuously with 8 random operand pairs -> accept every 4th cycle; every result matches a scoreboard of a+b+cin.
